// File: rtl/uart_tx_engine.sv
// UART transmit engine: serialises one byte per accepted handshake as
// start / 5-8 data bits LSB first / optional parity / 1-2 stop bits.
module uart_tx_engine (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] baud_divisor,
  input  logic [2:0]  data_bits,
  input  logic [1:0]  parity_mode,
  input  logic        two_stop_bits,
  input  logic        tx_enable,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        txd,
  output logic        tx_busy,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] div_q, div_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  idx_q, idx_d;
  logic [2:0]  last_q, last_d;
  logic        par_en_q, par_en_d;
  logic        par_bit_q, par_bit_d;
  logic        two_stop_q, two_stop_d;
  logic        txd_q, txd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        bit_end;

  // Index of the last data bit: 5..8 bits maps to 4..7; codes 4-7 mean 8 bits.
  function automatic logic [2:0] last_index(input logic [2:0] db);
    if (db >= 3'd3) begin
      return 3'd7;
    end else begin
      return db + 3'd4;
    end
  endfunction

  function automatic logic parity_bit(input logic [7:0] d, input logic [2:0] last,
                                      input logic [1:0] mode);
    logic [7:0] mask;
    logic       x;
    mask = 8'hFF >> (3'd7 - last);
    x    = ^(d & mask);
    case (mode)
      2'b01:   return ~x;
      2'b10:   return x;
      default: return 1'b1;
    endcase
  endfunction

  assign tx_ready   = (state_q == IDLE) && tx_enable && !reset;
  assign bit_end    = (cnt_q == 16'd0);
  assign txd        = txd_q;
  assign tx_busy    = busy_q;
  assign frame_done = done_q;

  // Next-state logic: every bit reloads the counter from the shadowed divisor.
  always_comb begin
    state_d    = state_q;
    cnt_d      = bit_end ? div_q : (cnt_q - 16'd1);
    div_d      = div_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    last_d     = last_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;
    txd_d      = txd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d  = cnt_q;
        txd_d  = 1'b1;
        busy_d = 1'b0;
        if (tx_valid && tx_ready) begin
          state_d    = START;
          cnt_d      = baud_divisor;
          div_d      = baud_divisor;
          shift_d    = tx_data;
          idx_d      = 3'd0;
          last_d     = last_index(data_bits);
          par_en_d   = (parity_mode != 2'b00);
          par_bit_d  = parity_bit(tx_data, last_index(data_bits), parity_mode);
          two_stop_d = two_stop_bits;
          txd_d      = 1'b0;
          busy_d     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
          idx_d   = 3'd0;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == last_q) begin
            idx_d = 3'd0;
            if (par_en_q) begin
              state_d = PARITY;
              txd_d   = par_bit_q;
            end else begin
              state_d = STOP;
              txd_d   = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 3'd1;
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          txd_d   = 1'b1;
          idx_d   = 3'd0;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        txd_d = 1'b1;
        if (bit_end) begin
          if (two_stop_q && (idx_q == 3'd0)) begin
            idx_d = 3'd1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            idx_d   = 3'd0;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and frame shadow registers; reset abandons any partial frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 16'd0;
      div_q      <= 16'd0;
      shift_q    <= 8'd0;
      idx_q      <= 3'd0;
      last_q     <= 3'd0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
- Serial transmitter driven by the decoded UART configuration fields: baud divisor, data bits, parity mode, stop bits and TX enable.
- Accepts bytes over a valid/ready handshake and serialises each one onto `txd`: start bit, 5-8 data bits LSB first, optional parity, then 1 or 2 stop bits.
- Sits between the TX FIFO (or a direct byte source) and the pad.

Parameters:
- None. All timing comes from the runtime `baud_divisor` input.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- baud_divisor  input  16  bit period = baud_divisor+1 clk cycles
- data_bits  input  3  0=5, 1=6, 2=7, 3=8 data bits; 4-7 treated as 8
- parity_mode  input  2  00=none, 01=odd, 10=even, 11=mark (parity bit = 1)
- two_stop_bits  input  1  0=one stop bit, 1=two stop bits
- tx_enable  input  1  gates acceptance of new frames
- tx_data  input  8  byte to send; bits above the configured width are ignored
- tx_valid  input  1  source has a byte
- tx_ready  output  1  engine accepts a byte this cycle
- txd  output  1  serial line, idle high
- tx_busy  output  1  frame in progress
- frame_done  output  1  one-cycle pulse at frame end

Behaviour:
- Interface: one clock (`clk`); `reset` is synchronous and active-high.
- Reset values: txd=1, tx_ready=0 on the reset cycle, tx_busy=0, frame_done=0, FSM=IDLE, all counters 0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- tx_ready is combinational: tx_ready = (state==IDLE) && tx_enable && !reset.
- Accept: tx_valid && tx_ready on rising edge E.
  - At E, latch tx_data, baud_divisor, data_bits, parity_mode and two_stop_bits into a frame shadow.
  - Config input changes after E do not affect the frame in flight.
- At E+1: state=START, txd=0, tx_busy=1.
- Bit timing:
  - Each bit holds txd for exactly div+1 cycles, where div is the latched divisor.
  - A 16-bit down-counter loads div at each bit start; the bit ends on the cycle the counter reads 0.
  - div=0 gives a 1-cycle bit. No minimum divisor is enforced.
- Transitions:
  - START -> DATA.
  - DATA sends N bits LSB first (N = 5..8 from the latched data_bits). A 3-bit index counts 0..N-1.
  - DATA -> PARITY if parity_mode != 00, else -> STOP.
  - PARITY -> STOP.
  - STOP holds txd=1 for 1 or 2 bit periods, then -> IDLE.
- Parity is computed over the N transmitted bits only:
  - odd: bit = ~XOR, so total ones including the parity bit is odd.
  - even: bit = XOR.
  - mark: bit = 1.
- Frame length: (1+N+P+S)*(div+1) cycles, with P in {0,1} and S in {1,2}. txd=0 begins at E+1.
- End of frame:
  - frame_done pulses on the cycle the state returns to IDLE.
  - tx_busy falls on that same cycle.
  - txd stays 1.
- Back-to-back frames: the earliest next accept is the edge at the end of the first cycle in IDLE. This gives a fixed 1-cycle extra idle-high gap between frames.
- tx_enable deasserted mid-frame: the current frame completes normally; no new accepts while low.
- tx_valid without tx_ready: no effect, and tx_data is not sampled.
- Reset mid-frame: on the next edge txd=1, state=IDLE, no frame_done pulse, and the partial frame is abandoned.

Test Plan:
1. div=3, data_bits=3, parity=00, 1 stop, tx_data=0x55 -> txd = 0,1,0,1,0,1,0,1,0,1, each held 4 cycles (40 total). frame_done pulses at E+41. tx_ready is low from E+1 to E+40.
2. div=1, data_bits=2, parity=10, two_stop_bits=1, tx_data=0x83 -> start 0, data 1,1,0,0,0,0,0, parity 0, stop 1,1, each held 2 cycles (22 cycles). Bit 7 is not sent.
3. div=0, data_bits=0, tx_data=0x1F:
   - parity=01 -> parity bit 0.
   - parity=10 -> parity bit 1.
   - parity=11 -> parity bit 1.
   - Each frame is 8 cycles.
4. Change baud_divisor 3->7 and parity 00->10 at E+5 -> the frame in flight keeps 4-cycle bits and no parity. The next frame uses 8-cycle bits plus a parity bit.
5. Assert reset at E+10 of a div=3 frame -> txd=1 at E+11, tx_busy=0, no frame_done. A new byte is accepted cleanly after reset releases.
6. Hold tx_valid high for 3 bytes with div=0, 8N1:
   - Frames are separated by exactly 1 idle-high cycle.
   - Drop tx_enable mid-frame 2 -> frame 2 completes and byte 3 is held until tx_enable returns.
